// File: rtl/POLI_types_pkg.sv
// POLI_types_pkg: register selects, control/status bit positions and FSM states for poli_crc_engine
package POLI_types_pkg;
  localparam int WORD_SIZE = 32;
  typedef enum logic [3:0] {
    CRC_CONTROL = 4'h0,
    CRC_STATUS  = 4'h1,
    CRC_INPUT   = 4'h2,
    CRC_OUTPUT  = 4'h3
  } regsel_t;
  localparam int CTRL_CLEAR   = 0;
  localparam int CTRL_REFLECT = 1;
  localparam int CTRL_CLR_OVR = 2;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVERRUN = 2;
  typedef enum logic {IDLE, SHIFT} crc_state_t;
endpackage

// File: rtl/poli_crc_step.sv
// poli_crc_step: one MSB-first CRC bit update (combinational)
// Ports: i_crc current CRC, i_bit next message bit, o_crc updated CRC.
module poli_crc_step #(
  parameter int CRC_WIDTH = 32,
  parameter logic [CRC_WIDTH-1:0] POLY = CRC_WIDTH'(32'h04C11DB7)
) (
  input  logic [CRC_WIDTH-1:0] i_crc,
  input  logic                 i_bit,
  output logic [CRC_WIDTH-1:0] o_crc
);
  assign o_crc = {i_crc[CRC_WIDTH-2:0], 1'b0} ^ ((i_crc[CRC_WIDTH-1] ^ i_bit) ? POLY : '0);
endmodule

// File: rtl/poli_crc_engine.sv
// poli_crc_engine: register-mapped serial CRC engine, BITS_PER_CYCLE bits folded per clock
// Ports: CLK clock, RST async active-high reset, regsel/wen/ren/wdata register access,
//        rdata combinational read data (0 when ren low), busy = in SHIFT, irq = STATUS.done.
// Build option: define POLI_CRC_REFLECT_EN to add the stored CONTROL.REFLECT bit.
module poli_crc_engine #(
  parameter int WORD_SIZE = POLI_types_pkg::WORD_SIZE,
  parameter int CRC_WIDTH = 32,
  parameter logic [WORD_SIZE-1:0] POLY = WORD_SIZE'(32'h04C11DB7),
  parameter logic [CRC_WIDTH-1:0] INIT = '1,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  POLI_types_pkg::regsel_t  regsel,
  input  logic                     wen,
  input  logic                     ren,
  input  logic [WORD_SIZE-1:0]     wdata,
  output logic [WORD_SIZE-1:0]     rdata,
  output logic                     busy,
  output logic                     irq
);
  import POLI_types_pkg::*;
  localparam int STEPS = WORD_SIZE / BITS_PER_CYCLE;
  localparam int CW = $clog2(STEPS + 1);
  crc_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [WORD_SIZE-1:0] r_sreg, w_din, w_status, w_ctrl;
  logic [CRC_WIDTH-1:0] r_crc, w_crc_rd;
  logic r_done, r_ovr, w_refl, w_wr_ctrl, w_wr_in, w_rd_out, w_clear;
  logic [CRC_WIDTH-1:0] w_chain [BITS_PER_CYCLE+1];

  assign w_wr_ctrl = wen && regsel == CRC_CONTROL;
  assign w_wr_in   = wen && regsel == CRC_INPUT;
  assign w_rd_out  = ren && regsel == CRC_OUTPUT;
  assign w_clear   = w_wr_ctrl && wdata[CTRL_CLEAR];
  assign busy      = r_state == SHIFT;
  assign irq       = r_done;

`ifdef POLI_CRC_REFLECT_EN
  logic r_refl;
  logic [WORD_SIZE-1:0] w_wrev;
  logic [CRC_WIDTH-1:0] w_crev;
  assign w_wrev   = {<<{wdata}};
  assign w_crev   = {<<{r_crc}};
  assign w_refl   = r_refl;
  assign w_din    = r_refl ? w_wrev : wdata;
  assign w_crc_rd = r_refl ? w_crev : r_crc;
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_refl <= 1'b0;
    else if (w_wr_ctrl) r_refl <= wdata[CTRL_REFLECT];
`else
  assign w_refl   = 1'b0;
  assign w_din    = wdata;
  assign w_crc_rd = r_crc;
`endif

  // bit g of the step consumes the g-th most significant remaining input bit
  assign w_chain[0] = r_crc;
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    poli_crc_step #(.CRC_WIDTH(CRC_WIDTH), .POLY(POLY[CRC_WIDTH-1:0])) u_step (
      .i_crc(w_chain[g]),
      .i_bit(r_sreg[WORD_SIZE-1-g]),
      .o_crc(w_chain[g+1])
    );
  end

  always_comb begin
    w_status = '0;
    w_status[STAT_BUSY] = busy;
    w_status[STAT_DONE] = r_done;
    w_status[STAT_OVERRUN] = r_ovr;
    w_ctrl = '0;
    w_ctrl[CTRL_REFLECT] = w_refl;
    rdata = (!ren || RST) ? '0 :
            regsel == CRC_CONTROL ? w_ctrl :
            regsel == CRC_STATUS  ? w_status :
            regsel == CRC_OUTPUT  ? WORD_SIZE'(w_crc_rd) : '0;
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sreg  <= '0;
      r_crc   <= INIT;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      // CLEAR wins over both a new word and a same-cycle completion
      if (w_clear) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_crc   <= INIT;
        r_done  <= 1'b0;
      end else if (r_state == IDLE) begin
        if (w_wr_in) begin
          r_sreg  <= w_din;
          r_cnt   <= CW'(STEPS);
          r_done  <= 1'b0;
          r_state <= SHIFT;
        end else if (w_rd_out) r_done <= 1'b0;
      end else begin
        r_crc  <= w_chain[BITS_PER_CYCLE];
        r_sreg <= r_sreg << BITS_PER_CYCLE;
        r_cnt  <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
      end
      if (w_wr_ctrl && wdata[CTRL_CLR_OVR]) r_ovr <= 1'b0;
      else if (w_wr_in && r_state == SHIFT) r_ovr <= 1'b1;
    end
endmodule

// File: tb/tb_poli_crc_engine.sv
// tb_poli_crc_engine: directed self-checking bench, three engines sharing one register bus
module tb_poli_crc_engine;
  import POLI_types_pkg::*;
  logic CLK = 1'b0, RST = 1'b1, wen = 1'b0, ren = 1'b0;
  regsel_t sel = regsel_t'(4'hF);
  logic [31:0] wdata = '0;
  logic [31:0] rd [3];
  logic bz [3], iq [3];
  logic [31:0] rv [3];
  logic [31:0] exp_q [$];
  logic [31:0] e;
  int n_chk = 0, n_fail = 0, c0, c1;

  always #5 CLK = ~CLK;

  poli_crc_engine #(.INIT(32'h0)) dut0 (
    .CLK(CLK), .RST(RST), .regsel(sel), .wen(wen), .ren(ren), .wdata(wdata),
    .rdata(rd[0]), .busy(bz[0]), .irq(iq[0]));
  poli_crc_engine #(.INIT(32'h0), .BITS_PER_CYCLE(4)) dut1 (
    .CLK(CLK), .RST(RST), .regsel(sel), .wen(wen), .ren(ren), .wdata(wdata),
    .rdata(rd[1]), .busy(bz[1]), .irq(iq[1]));
  poli_crc_engine dut2 (
    .CLK(CLK), .RST(RST), .regsel(sel), .wen(wen), .ren(ren), .wdata(wdata),
    .rdata(rd[2]), .busy(bz[2]), .irq(iq[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input regsel_t s, input logic [31:0] d);
    sel = s;
    wdata = d;
    wen = 1'b1;
    cyc(1);
    wen = 1'b0;
    sel = regsel_t'(4'hF);
  endtask

  task automatic rdreg(input regsel_t s);
    sel = s;
    ren = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) rv[k] = rd[k];
    cyc(1);
    ren = 1'b0;
    sel = regsel_t'(4'hF);
  endtask

  task automatic wait_done();
    c0 = -1;
    c1 = -1;
    for (int c = 1; c <= 64 && c0 < 0; c++) begin
      cyc(1);
      if (iq[1] && c1 < 0) c1 = c;
      if (iq[0]) c0 = c;
    end
  endtask

  task automatic pop_out(input string tag);
    rdreg(CRC_OUTPUT);
    e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
    chk({tag, "_b1"}, rv[0], e);
    chk({tag, "_b4"}, rv[1], e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel = CRC_OUTPUT;
    ren = 1'b1;
    cyc(2);
    chk("rst_rdata", rd[2], 32'h0);
    chk("rst_busy", 32'(bz[2]), 32'h0);
    chk("rst_irq", 32'(iq[2]), 32'h0);
    ren = 1'b0;
    sel = regsel_t'(4'hF);
    RST = 1'b0;
    rdreg(CRC_OUTPUT);
    chk("init_out_zero", rv[0], 32'h0);
    chk("init_out_ones", rv[2], 32'hFFFF_FFFF);
    rdreg(CRC_STATUS);
    chk("init_stat", rv[0], 32'h0);
    rdreg(regsel_t'(4'h7));
    chk("unmapped_rd", rv[2], 32'h0);
    wr(CRC_STATUS, 32'hFFFF_FFFF);
    wr(CRC_OUTPUT, 32'hFFFF_FFFF);
    rdreg(CRC_STATUS);
    chk("ro_stat", rv[2], 32'h0);

    wr(CRC_INPUT, 32'h0000_0001);
    exp_q.push_back(32'h04C1_1DB7);
    wait_done();
    chk("lat_b1", 32'(c0), 32'd32);
    chk("lat_b4", 32'(c1), 32'd8);
    rdreg(CRC_STATUS);
    chk("done_set", rv[0], 32'h2);
    pop_out("word1");
    rdreg(CRC_STATUS);
    chk("done_clr", rv[0], 32'h0);

    wr(CRC_CONTROL, 32'h1);
    wr(CRC_INPUT, 32'h0000_0002);
    exp_q.push_back(32'h0982_3B6E);
    wait_done();
    chk("lat2_b1", 32'(c0), 32'd32);
    chk("lat2_b4", 32'(c1), 32'd8);
    pop_out("word2");

    wr(CRC_CONTROL, 32'h1);
    wr(CRC_INPUT, 32'h0000_0001);
    exp_q.push_back(32'h04C1_1DB7);
    cyc(4);
    wr(CRC_INPUT, 32'hDEAD_BEEF);
    rdreg(CRC_STATUS);
    chk("ovr_stat_b1", rv[0], 32'h5);
    chk("ovr_stat_b4", rv[1], 32'h5);
    wait_done();
    pop_out("ovr_word");
    wr(CRC_CONTROL, 32'h4);
    rdreg(CRC_STATUS);
    chk("ovr_clr", rv[0], 32'h0);

    wr(CRC_INPUT, 32'h1234_5678);
    cyc(3);
    chk("busy_mid", 32'(bz[2]), 32'h1);
    wr(CRC_CONTROL, 32'h1);
    chk("clr_busy", 32'(bz[2]), 32'h0);
    chk("clr_busy_b1", 32'(bz[0]), 32'h0);
    rdreg(CRC_OUTPUT);
    chk("clr_out_ones", rv[2], 32'hFFFF_FFFF);
    chk("clr_out_zero", rv[0], 32'h0);
    rdreg(CRC_STATUS);
    chk("clr_stat", rv[2], 32'h0);

    wr(CRC_INPUT, 32'hCAFE_F00D);
    cyc(3);
    sel = CRC_OUTPUT;
    ren = 1'b1;
    #1;
    RST = 1'b1;
    #1;
    chk("rstmid_rdata", rd[2], 32'h0);
    chk("rstmid_busy", 32'(bz[2]), 32'h0);
    chk("rstmid_irq", 32'(iq[0]), 32'h0);
    cyc(1);
    #2;
    RST = 1'b0;
    ren = 1'b0;
    sel = regsel_t'(4'hF);
    cyc(1);
    rdreg(CRC_OUTPUT);
    chk("rstmid_out", rv[2], 32'hFFFF_FFFF);
    rdreg(CRC_STATUS);
    chk("rstmid_stat", rv[2], 32'h0);

`ifdef POLI_CRC_REFLECT_EN
    wr(CRC_CONTROL, 32'h3);
    rdreg(CRC_CONTROL);
    chk("refl_rd", rv[0], 32'h2);
    wr(CRC_INPUT, 32'h8000_0000);
    exp_q.push_back(32'hEDB8_8320);
    wait_done();
    pop_out("refl");
    wr(CRC_CONTROL, 32'h1);
    rdreg(CRC_CONTROL);
    chk("refl_off", rv[0], 32'h0);
`else
    wr(CRC_CONTROL, 32'h2);
    rdreg(CRC_CONTROL);
    chk("refl_absent", rv[0], 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
